skein_round_sequencer: RTL and testbench
========================================

// Module: skein_round_sequencer
// PURPOSE
//  Generates the word and round counters that drive chip_mode_register and the Threefish-512 datapath for one block.
//  Steps words 0..WORDS_PER_PASS inside each pass; word==WORDS_PER_PASS is the one-cycle pass-end slot where the mode register advances.
//  Tracks rounds and subkey index from the fed-back chip mode; signals completion after the final subkey add.
// PARAMETERS
//  NUM_ROUNDS      72  Threefish rounds per block
//  WORDS_PER_PASS  16  word cycles per pass, excluding the pass-end slot
//  NUM_SUBKEYS     19  subkey injections, = NUM_ROUNDS/4+1
// PORTS
//  clk_i            in   1  clock; single clock domain
//  rst_ni           in   1  asynchronous active-low reset
//  start_i          in   1  begin a block; sampled only in IDLE
//  stall_i          in   1  hold word counter; honoured only while word_counter_o<WORDS_PER_PASS
//  chip_mode_i      in   2  chip_mode_o fed back: 0 subkey gen, 1 subkey add, 2 threefish, 3 illegal
//  word_counter_o   out  6  word index 0..WORDS_PER_PASS; drives word_counter_i
//  round_counter_o  out  7  completed threefish passes 0..NUM_ROUNDS; drives round_counter_i
//  subkey_idx_o     out  5  index of current subkey 0..NUM_SUBKEYS-1
//  pass_end_o       out  1  high when word_counter_o==WORDS_PER_PASS
//  busy_o           out  1  high in RUN
//  done_o           out  1  one-cycle pulse, block complete
//  err_o            out  1  sticky, illegal chip mode seen in RUN
// BEHAVIOUR
//  Reset, async on rst_ni low: state=IDLE; all counters 0; pass_end_o, busy_o, done_o and err_o are 0.
//  FSM states: IDLE, RUN, DONE. The FSM and all counters are registered. Outputs come straight from registers.
//  IDLE:
//   - Counters hold 0.
//   - start_i=1 at an edge -> RUN. Clears word, round, subkey and err to 0.
//   - word_counter_o=0 from the next cycle.
//  RUN, word<WORDS_PER_PASS:
//   - Word increments by 1 per cycle.
//   - stall_i=1 holds all counters.
//  RUN, word==WORDS_PER_PASS (pass-end slot):
//   - Exactly one cycle; stall_i is ignored, so the mode register never double-advances.
//   - Word wraps to 0 at the next edge.
//   - chip_mode_i==2: round increments, saturating at NUM_ROUNDS.
//   - chip_mode_i==1 and subkey<NUM_SUBKEYS-1: subkey increments.
//   - chip_mode_i==1 and subkey==NUM_SUBKEYS-1: -> DONE; word, round and subkey clear to 0.
//   - chip_mode_i==0: counters other than word unchanged.
//  RUN, chip_mode_i==3 on any cycle:
//   - err_o=1, sticky until next accepted start.
//   - -> IDLE next edge; counters cleared.
//  DONE:
//   - done_o=1, busy_o=0 for one cycle.
//   - Unconditional -> IDLE.
//   - start_i in DONE is ignored.
//  start_i while in RUN is ignored; a run cannot be restarted except by reset.
//  Timing:
//   - Pass length is WORDS_PER_PASS+1 cycles.
//   - Block = 2*NUM_SUBKEYS + NUM_ROUNDS = 110 passes = 1870 cycles at no stall.
//  Reset mid-run returns to IDLE immediately; no done_o is produced.
// TESTING
//  1 Reset with counters mid-count -> all outputs 0 asynchronously, state IDLE.
//  2 Start at cycle T, modelled chip_mode_register in loop, no stall:
//    -> word 0 at T+1; pass_end_o at T+17, T+34, ...
//    -> done_o only at T+1871; round_counter_o reached 72, subkey_idx_o reached 18 before clearing.
//  3 stall_i high 5 cycles at word 7 -> word holds 7; done_o shifts by exactly 5 cycles.
//  4 stall_i high across pass-end slot -> slot lasts 1 cycle, word wraps to 0, then stall takes effect at word 0.
//  5 Force chip_mode_i=3 at word 4 of round 10 -> err_o=1 next cycle, busy_o=0, counters 0; next start clears err_o.
//  6 start_i pulsed mid-run and during DONE -> no effect; round/subkey sequence and done timing unchanged.

Source files
------------

// File: rtl/skein_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : skein_round_sequencer
// Description : Word/round/subkey sequencer for one Threefish-512 block,
//               stepping pass-by-pass under control of the fed-back chip mode.
// Revision    : 1.0 - initial release
// ============================================================================
module skein_round_sequencer #(
  parameter int NUM_ROUNDS     = 72,
  parameter int WORDS_PER_PASS = 16,
  parameter int NUM_SUBKEYS    = 19
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stall_i,
  input  logic [1:0] chip_mode_i,
  output logic [5:0] word_counter_o,
  output logic [6:0] round_counter_o,
  output logic [4:0] subkey_idx_o,
  output logic       pass_end_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [5:0] c_LAST_WORD   = 6'(WORDS_PER_PASS);
  localparam logic [6:0] c_MAX_ROUND   = 7'(NUM_ROUNDS);
  localparam logic [4:0] c_LAST_SUBKEY = 5'(NUM_SUBKEYS - 1);

  localparam logic [1:0] c_MODE_SKGEN   = 2'd0;
  localparam logic [1:0] c_MODE_SKADD   = 2'd1;
  localparam logic [1:0] c_MODE_TF      = 2'd2;
  localparam logic [1:0] c_MODE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [5:0] word_q, word_d;
  logic [6:0] round_q, round_d;
  logic [4:0] subkey_q, subkey_d;
  logic       err_q, err_d;
  logic       pass_end_q, pass_end_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    round_d  = round_q;
    subkey_d = subkey_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        word_d   = '0;
        round_d  = '0;
        subkey_d = '0;
        if (start_i) begin
          state_d = S_RUN;
          err_d   = 1'b0;
        end
      end

      S_RUN: begin
        if (chip_mode_i == c_MODE_ILLEGAL) begin
          state_d  = S_IDLE;
          err_d    = 1'b1;
          word_d   = '0;
          round_d  = '0;
          subkey_d = '0;
        end else if (word_q < c_LAST_WORD) begin
          if (!stall_i) begin
            word_d = word_q + 6'd1;
          end
        end else begin
          // Pass-end slot: always exactly one cycle so the mode register
          // sees a single advance per pass.
          word_d = '0;
          case (chip_mode_i)
            c_MODE_TF: begin
              if (round_q < c_MAX_ROUND) begin
                round_d = round_q + 7'd1;
              end
            end
            c_MODE_SKADD: begin
              if (subkey_q == c_LAST_SUBKEY) begin
                state_d  = S_DONE;
                round_d  = '0;
                subkey_d = '0;
              end else begin
                subkey_d = subkey_q + 5'd1;
              end
            end
            c_MODE_SKGEN: begin
            end
            default: begin
            end
          endcase
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        word_d   = '0;
        round_d  = '0;
        subkey_d = '0;
      end

      default: begin
        state_d  = S_IDLE;
        word_d   = '0;
        round_d  = '0;
        subkey_d = '0;
      end
    endcase

    pass_end_d = (state_d == S_RUN) && (word_d == c_LAST_WORD);
    busy_d     = (state_d == S_RUN);
    done_d     = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      round_q    <= '0;
      subkey_q   <= '0;
      err_q      <= 1'b0;
      pass_end_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      round_q    <= round_d;
      subkey_q   <= subkey_d;
      err_q      <= err_d;
      pass_end_q <= pass_end_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign word_counter_o  = word_q;
  assign round_counter_o = round_q;
  assign subkey_idx_o    = subkey_q;
  assign pass_end_o      = pass_end_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;
  assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_skein_round_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_skein_round_sequencer
// Description : Self-checking bench; a linear-progress model drives the chip
//               mode feedback and predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skein_round_sequencer;

  localparam int PASS_LEN     = 17;
  localparam int BLOCK_CYCLES = 110 * PASS_LEN;

  logic       clk;
  logic       rst_ni;
  logic       start_i;
  logic       stall_i;
  logic [1:0] chip_mode_i;
  logic [5:0] word_counter_o;
  logic [6:0] round_counter_o;
  logic [4:0] subkey_idx_o;
  logic       pass_end_o;
  logic       busy_o;
  logic       done_o;
  logic       err_o;

  skein_round_sequencer dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .stall_i        (stall_i),
    .chip_mode_i    (chip_mode_i),
    .word_counter_o (word_counter_o),
    .round_counter_o(round_counter_o),
    .subkey_idx_o   (subkey_idx_o),
    .pass_end_o     (pass_end_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  bit force3 = 1'b0;
  int max_round;
  int max_sub;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Block schedule in groups of six passes: gen, add, then four threefish.
  function automatic int mode_of(input int p);
    int r;
    r = p % 6;
    if (r == 0) return 0;
    if (r == 1) return 1;
    return 2;
  endfunction

  function automatic int rounds_done(input int p);
    int r;
    r = p % 6;
    return (p / 6) * 4 + ((r > 2) ? (r - 2) : 0);
  endfunction

  function automatic int subkeys_done(input int p);
    return (p / 6) + (((p % 6) >= 2) ? 1 : 0);
  endfunction

  // Model: m_n counts word-cycles of progress through the block.
  bit m_active, m_donep, m_err;
  int m_n;

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      m_active <= 1'b0;
      m_donep  <= 1'b0;
      m_err    <= 1'b0;
      m_n      <= 0;
    end else if (m_donep) begin
      m_donep <= 1'b0;
    end else if (!m_active) begin
      if (start_i) begin
        m_active <= 1'b1;
        m_n      <= 0;
        m_err    <= 1'b0;
      end
    end else if (chip_mode_i == 2'd3) begin
      m_active <= 1'b0;
      m_err    <= 1'b1;
      m_n      <= 0;
    end else if (stall_i && (m_n % PASS_LEN) != PASS_LEN - 1) begin
      m_n <= m_n;
    end else if (m_n + 1 == BLOCK_CYCLES) begin
      m_active <= 1'b0;
      m_donep  <= 1'b1;
      m_n      <= 0;
    end else begin
      m_n <= m_n + 1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign chip_mode_i = force3   ? 2'd3 :
                       m_active ? 2'(mode_of(m_n / PASS_LEN)) : 2'd0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("word",     int'(word_counter_o),  m_active ? m_n % PASS_LEN : 0);
      chk("round",    int'(round_counter_o), m_active ? rounds_done(m_n / PASS_LEN) : 0);
      chk("subkey",   int'(subkey_idx_o),    m_active ? subkeys_done(m_n / PASS_LEN) : 0);
      chk("pass_end", int'(pass_end_o),      int'(m_active && (m_n % PASS_LEN) == PASS_LEN - 1));
      chk("busy",     int'(busy_o),          int'(m_active));
      chk("done",     int'(done_o),          int'(m_donep));
      chk("err",      int'(err_o),           int'(m_err));
    end
  end

  task automatic do_block(input int stall_n, input int stall_len, input bit poke,
                          output int dur, output int first_pe);
    int s;
    int left;
    bit stall_used;
    dur = -1; first_pe = -1; left = 0; stall_used = 1'b0;
    max_round = 0; max_sub = 0;
    @(negedge clk);
    start_i = 1'b1;
    s = cyc;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if (int'(round_counter_o) > max_round) max_round = int'(round_counter_o);
      if (int'(subkey_idx_o) > max_sub) max_sub = int'(subkey_idx_o);
      if (pass_end_o && first_pe < 0) first_pe = cyc - s;
      if (done_o) begin
        dur = cyc - s;
        break;
      end
      stall_i = 1'b0;
      start_i = 1'b0;
      if (left > 0) begin
        stall_i = 1'b1;
        left--;
      end else if (!stall_used && stall_len > 0 && m_n == stall_n) begin
        stall_used = 1'b1;
        stall_i = 1'b1;
        left = stall_len - 1;
      end
      if (poke && m_active && m_n == 500) start_i = 1'b1;
      @(negedge clk);
    end
    stall_i = 1'b0;
    start_i = 1'b0;
    if (poke) begin
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("idle_after_done", int'(busy_o), 0);
  endtask

  initial begin
    int dur, pe;
    rst_ni  = 1'b0;
    start_i = 1'b0;
    stall_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_word",  int'(word_counter_o), 0);
    chk("reset_busy",  int'(busy_o), 0);
    chk("reset_err",   int'(err_o), 0);

    // Plain block, no stall
    do_block(-1, 0, 1'b0, dur, pe);
    chk("first_pass_end", pe, 17);
    chk("done_latency",   dur, 1871);
    chk("max_round",      max_round, 72);
    chk("max_subkey",     max_sub, 18);

    // Five-cycle stall at word 7
    do_block(7, 5, 1'b0, dur, pe);
    chk("stall_done_latency", dur, 1876);

    // Stall straddling the pass-end slot: only two cycles take effect
    do_block(16, 3, 1'b0, dur, pe);
    chk("slot_stall_latency", dur, 1873);
    chk("slot_stall_first_pe", pe, 17);

    // Start pulses mid-run and in DONE
    do_block(-1, 0, 1'b1, dur, pe);
    chk("poke_done_latency", dur, 1871);
    chk("poke_max_round",    max_round, 72);

    // Illegal mode at word 4 of round 10
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int i = 0; i < 400 && m_n != 16 * PASS_LEN + 4; i++) @(negedge clk);
    chk("pre_err_round", int'(round_counter_o), 10);
    chk("pre_err_word",  int'(word_counter_o), 4);
    force3 = 1'b1;
    @(negedge clk);
    force3 = 1'b0;
    chk("err_set",   int'(err_o), 1);
    chk("err_busy",  int'(busy_o), 0);
    chk("err_round", int'(round_counter_o), 0);
    repeat (3) @(negedge clk);
    chk("err_sticky", int'(err_o), 1);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    chk("err_cleared", int'(err_o), 0);
    chk("restart_busy", int'(busy_o), 1);

    // Asynchronous reset mid-count
    repeat (300) @(negedge clk);
    @(posedge clk);
    #2 rst_ni = 1'b0;
    #1;
    chk("async_word",     int'(word_counter_o), 0);
    chk("async_round",    int'(round_counter_o), 0);
    chk("async_subkey",   int'(subkey_idx_o), 0);
    chk("async_pass_end", int'(pass_end_o), 0);
    chk("async_busy",     int'(busy_o), 0);
    chk("async_done",     int'(done_o), 0);
    chk("async_err",      int'(err_o), 0);
    @(negedge clk);
    #2 rst_ni = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", int'(busy_o), 0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no end expected end by t=%0t", $time);
    $fatal(1);
  end

endmodule
`default_nettype wire
